// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem fetches,
// and feeds fetched words with their PC+4 into the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        out_valid
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        out_valid_q, out_valid_d;
  logic        imem_req_q, imem_req_d;

  logic        slot_free;
  logic        consume;
  logic        load;
  logic [31:0] load_data;
  logic [31:0] pc_inc;

  assign pc_inc    = pc_q + 32'd4;
  assign slot_free = !out_valid_q || !stall;
  assign consume   = out_valid_q && !stall && !redirect;

  // Next-state, PC, output register and skid buffer updates.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_plus4_d  = pc_plus4_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    load_data   = imem_rdata;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (slot_free) begin
            load    = 1'b1;
            state_d = REQ;
          end else begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          load      = 1'b1;
          load_data = skid_q;
          state_d   = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      out_valid_d = 1'b0;
      instr_d     = NOP_INSTR;
    end

    if (load) begin
      instr_d     = load_data;
      pc_plus4_d  = pc_inc;
      out_valid_d = 1'b1;
      pc_d        = pc_inc;
    end

    // A flush overrides any load or hold decided above.
    if (redirect) begin
      pc_d        = {redirect_pc[31:2], 2'b00};
      out_valid_d = 1'b0;
      instr_d     = NOP_INSTR;
      pc_plus4_d  = pc_plus4_q;
      skid_d      = '0;
      unique case (state_q)
        REQ:     state_d = DROP;
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end

    imem_req_d  = (state_d == REQ);
    imem_addr_d = imem_req_d ? pc_d : imem_addr_q;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc_plus4_q  <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_plus4_q  <= pc_plus4_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign instr     = instr_q;
  assign pc_plus4  = pc_plus4_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed timing steps, a wrap instance,
// then random stall/redirect/latency against an in-order fetch scoreboard.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        out_valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_ov;

  int errors = 0;
  int checks = 0;

  if_fetch_unit u_dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc_plus4    (pc_plus4),
    .out_valid   (out_valid)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk         (clk),
    .rst         (rst),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_rvalid (w_rvalid),
    .imem_rdata  (w_rdata),
    .instr       (w_instr),
    .pc_plus4    (w_pc4),
    .out_valid   (w_ov)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    w_rvalid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  // Instruction memory: answers each request after lat cycles.
  int          lat = 1;
  bit          lat_rand = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (rst) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word(paddr);
        end
      end
      if (imem_req) begin
        paddr = imem_addr;
        cnt = lat_rand ? int'($urandom_range(1, 3)) : lat;
      end
    end
  end

  // Scoreboard: requests walk +4 from the last target, flushes drop
  // everything outstanding, consumed words arrive in request order.
  bit          mon_en = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_q[$];
  int          delivered = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        exp_q.delete();
        exp_addr = 32'h0;
      end else begin
        if (imem_req) begin
          chk("req_addr", imem_addr, exp_addr);
          exp_q.push_back(exp_addr);
          exp_addr = exp_addr + 32'd4;
        end
        if (!out_valid) begin
          chk("bubble_instr", instr, NOP);
        end else if (!stall && !redirect) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'd1, 32'd0);
          end else begin
            logic [31:0] a;
            a = exp_q.pop_front();
            chk("deliver_instr", instr, word(a));
            chk("deliver_pc4", pc_plus4, a + 32'd4);
            delivered++;
          end
        end
        if (redirect) begin
          exp_q.delete();
          exp_addr = {redirect_pc[31:2], 2'b00};
        end
      end
    end
  end

  initial begin
    // T1 reset values, then IDLE, then first request.
    step();
    chk("t1_ov", {31'b0, out_valid}, 32'd0);
    chk("t1_instr", instr, NOP);
    chk("t1_pc4", pc_plus4, 32'd0);
    chk("t1_req", {31'b0, imem_req}, 32'd0);
    chk("t1_addr", imem_addr, 32'd0);
    rst = 1'b0;
    chk("t1_idle_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("t1_req_on", {31'b0, imem_req}, 32'd1);
    chk("t1_req_addr", imem_addr, 32'd0);

    // T2 streaming with 1-cycle memory.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_gap_ov", {31'b0, out_valid}, 32'd0);
      chk("t2_gap_instr", instr, NOP);
      step();
      chk("t2_ov", {31'b0, out_valid}, 32'd1);
      chk("t2_instr", instr, word(32'(4 * k)));
      chk("t2_pc4", pc_plus4, 32'(4 * k + 4));
      chk("t2_req", {31'b0, imem_req}, 32'd1);
      chk("t2_addr", imem_addr, 32'(4 * k + 4));
    end

    // T3 stall while the second word returns.
    do_reset();
    step();
    step();
    chk("t3_a", instr, word(32'd0));
    stall = 1'b1;
    step();
    chk("t3_hold_a", instr, word(32'd0));
    chk("t3_hold_ov", {31'b0, out_valid}, 32'd1);
    chk("t3_no_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("t3_skid_a", instr, word(32'd0));
    chk("t3_skid_pc4", pc_plus4, 32'd4);
    chk("t3_skid_req", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    step();
    chk("t3_b", instr, word(32'd4));
    chk("t3_b_pc4", pc_plus4, 32'd8);
    chk("t3_b_ov", {31'b0, out_valid}, 32'd1);
    chk("t3_b_req", {31'b0, imem_req}, 32'd1);
    chk("t3_b_addr", imem_addr, 32'd8);
    step();
    chk("t3_gap", {31'b0, out_valid}, 32'd0);
    step();
    chk("t3_c", instr, word(32'd8));
    chk("t3_c_pc4", pc_plus4, 32'hC);

    // T4 redirect while waiting on a 3-cycle memory.
    lat = 3;
    do_reset();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("t4_ov", {31'b0, out_valid}, 32'd0);
    chk("t4_req0", {31'b0, imem_req}, 32'd0);
    step();
    chk("t4_req1", {31'b0, imem_req}, 32'd0);
    step();
    chk("t4_req", {31'b0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_drop_ov", {31'b0, out_valid}, 32'd0);
    chk("t4_drop_instr", instr, NOP);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_wait_ov", {31'b0, out_valid}, 32'd0);
    end
    step();
    chk("t4_new_ov", {31'b0, out_valid}, 32'd1);
    chk("t4_new_instr", instr, word(32'h100));
    chk("t4_new_pc4", pc_plus4, 32'h104);
    lat = 1;

    // T5 redirect, rvalid and stall in the same cycle.
    do_reset();
    step();
    step();
    stall = 1'b1;
    step();
    chk("t5_held", instr, word(32'd0));
    redirect = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    stall = 1'b0;
    chk("t5_ov", {31'b0, out_valid}, 32'd0);
    chk("t5_instr", instr, NOP);
    chk("t5_req", {31'b0, imem_req}, 32'd1);
    chk("t5_addr", imem_addr, 32'h200);
    step();
    step();
    chk("t5_new_instr", instr, word(32'h200));
    chk("t5_new_pc4", pc_plus4, 32'h204);

    // T6 PC wrap from the top of the address space.
    do_reset();
    chk("t6_req", {31'b0, w_req}, 32'd1);
    chk("t6_addr", w_addr, 32'hFFFF_FFFC);
    step();
    w_rvalid = 1'b1;
    w_rdata = 32'hC0DE_0006;
    step();
    w_rvalid = 1'b0;
    chk("t6_ov", {31'b0, w_ov}, 32'd1);
    chk("t6_instr", w_instr, 32'hC0DE_0006);
    chk("t6_pc4", w_pc4, 32'h0);
    chk("t6_next_req", {31'b0, w_req}, 32'd1);
    chk("t6_next_addr", w_addr, 32'h0);

    // Random stall, redirect and latency, with one mid-run reset.
    do_reset();
    exp_q.delete();
    exp_addr = 32'h0;
    lat_rand = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      if (c == 1500) rst = 1'b1;
      if (c == 1502) rst = 1'b0;
      step();
    end
    stall = 1'b0;
    redirect = 1'b0;
    repeat (10) step();
    mon_en = 1'b0;
    chk("liveness", {31'b0, delivered > 100}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
